// File: rtl/svm_loader.sv
// Framed word-stream loader for the 21-6-3 SVM weight/bias banks and sample register.
// Define SVM_LOADER_CHECKSUM_EN to require a wrapping-sum trailer word on every frame.
module svm_loader #(
  parameter int unsigned DIMS    = 21,
  parameter int unsigned INTER   = 6,
  parameter int unsigned CLASSES = 3,
  parameter int unsigned W       = 16
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  input  logic         err_clr_i,
  output logic [W-1:0] feats_o   [DIMS][INTER],
  output logic [W-1:0] biases_o  [INTER],
  output logic [W-1:0] feats2_o  [INTER][CLASSES],
  output logic [W-1:0] biases2_o [CLASSES],
  output logic [W-1:0] din_o     [DIMS],
  output logic         params_valid_o,
  output logic         sample_valid_o,
  output logic [2:0]   err_o
);

  localparam int unsigned B1 = DIMS * INTER;
  localparam int unsigned F2 = B1 + INTER;
  localparam int unsigned B2 = F2 + INTER * CLASSES;
  localparam int unsigned NP = B2 + CLASSES;

  typedef enum logic [2:0] {
    StIdle,
    StParam,
    StSample,
`ifdef SVM_LOADER_CHECKSUM_EN
    StChk,
`endif
    StCommit
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_param_q, is_param_d;
  logic        pv_q, pv_d;
  logic [2:0]  err_q, err_d, err_set;
  logic        accept, wr_param, wr_sample, csum_ok;
  logic [W-1:0] bank_q [NP];
  logic [W-1:0] din_q  [DIMS];

`ifdef SVM_LOADER_CHECKSUM_EN
  logic [W-1:0] csum_q, csum_d;
  logic         csum_ok_q, csum_ok_d;
  assign csum_ok = csum_ok_q;
  localparam state_e StLast = StChk;
`else
  assign csum_ok = 1'b1;
  localparam state_e StLast = StCommit;
`endif

  assign s_ready_o = (state_q != StCommit);
  assign accept    = s_valid_i && s_ready_o;
  assign wr_param  = accept && (state_q == StParam);
  assign wr_sample = accept && (state_q == StSample);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_param_d = is_param_q;
    pv_d       = pv_q;
    err_set    = 3'b000;
`ifdef SVM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    csum_ok_d  = csum_ok_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = 8'd0;
`ifdef SVM_LOADER_CHECKSUM_EN
          csum_d    = '0;
          csum_ok_d = 1'b1;
`endif
          if (s_data_i[15:12] == 4'h1) begin
            state_d    = StParam;
            is_param_d = 1'b1;
            pv_d       = 1'b0;
          end else if (s_data_i[15:12] == 4'h2) begin
            state_d    = StSample;
            is_param_d = 1'b0;
          end else begin
            err_set[0] = 1'b1;
          end
        end
      end
      StParam, StSample: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
`ifdef SVM_LOADER_CHECKSUM_EN
          csum_d = csum_q + s_data_i;
`endif
          if ((state_q == StParam  && cnt_q == 8'(NP - 1)) ||
              (state_q == StSample && cnt_q == 8'(DIMS - 1))) begin
            state_d = StLast;
          end
        end
      end
`ifdef SVM_LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          csum_ok_d  = (s_data_i == csum_q);
          err_set[2] = (s_data_i != csum_q);
          state_d    = StCommit;
        end
      end
`endif
      StCommit: begin
        state_d = StIdle;
        if (is_param_q) begin
          if (csum_ok) pv_d = 1'b1;
        end else if (!pv_q) begin
          err_set[1] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Set has priority over a simultaneous clear.
    err_d = (err_q & ~{3{err_clr_i}}) | err_set;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      is_param_q <= 1'b0;
      pv_q       <= 1'b0;
      err_q      <= 3'b000;
`ifdef SVM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      csum_ok_q  <= 1'b1;
`endif
      for (int k = 0; k < NP; k++) bank_q[k] <= '0;
      for (int k = 0; k < DIMS; k++) din_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_param_q <= is_param_d;
      pv_q       <= pv_d;
      err_q      <= err_d;
`ifdef SVM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      csum_ok_q  <= csum_ok_d;
`endif
      for (int k = 0; k < NP; k++) begin
        if (wr_param && cnt_q == 8'(k)) bank_q[k] <= s_data_i;
      end
      for (int k = 0; k < DIMS; k++) begin
        if (wr_sample && cnt_q == 8'(k)) din_q[k] <= s_data_i;
      end
    end
  end

  assign params_valid_o = pv_q;
  assign sample_valid_o = (state_q == StCommit) && !is_param_q && pv_q && csum_ok;
  assign err_o          = err_q;

  // Flat parameter bank, sliced in stream order onto the classifier inputs.
  for (genvar d = 0; d < DIMS; d++) begin : g_f1
    for (genvar i = 0; i < INTER; i++) begin : g_f1i
      assign feats_o[d][i] = bank_q[d * INTER + i];
    end
    assign din_o[d] = din_q[d];
  end
  for (genvar i = 0; i < INTER; i++) begin : g_f2
    assign biases_o[i] = bank_q[B1 + i];
    for (genvar c = 0; c < CLASSES; c++) begin : g_f2c
      assign feats2_o[i][c] = bank_q[F2 + i * CLASSES + c];
    end
  end
  for (genvar c = 0; c < CLASSES; c++) begin : g_b2
    assign biases2_o[c] = bank_q[B2 + c];
  end

endmodule
